aes_spi_frame_if: RTL and testbench

Synchronous SPI-slave framing front-end for the AES encrypt/decrypt cores. It deserialises key and plaintext/ciphertext frames from the SPI master on `sdi`, hands a complete 128-bit block to the AES datapath with a start/done handshake, and serialises the 128-bit result back on `sdo` during the next read frame. One instance sits between the shared SPI bus (`cs`, `sdi`, `sdo`) and each AES core, replacing that core's ad-hoc shift logic.

---
 rtl/aes_spi_frame_if.sv | 155 +++++++++++++++
 tb/tb_aes_spi_frame_if.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_frame_if.sv
// SPI-slave framing front-end for an AES core: collects key and data frames,
// launches the core, and streams the 128-bit result back during a read frame.
module aes_spi_frame_if #(
  parameter int KEY_FRAME_BITS = 258,
  parameter int BLK_BITS       = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      sdi,
  output logic                      sdo,
  output logic [1:0]                key_mode,
  output logic [KEY_FRAME_BITS-3:0] key,
  output logic                      key_valid,
  output logic [BLK_BITS-1:0]       block_out,
  output logic                      core_start,
  input  logic                      core_done,
  input  logic [BLK_BITS-1:0]       core_result,
  output logic                      busy,
  output logic                      frame_err
);

  localparam logic [8:0] KEY_LEN = 9'(KEY_FRAME_BITS);
  localparam logic [8:0] BLK_LEN = 9'(BLK_BITS);

  typedef enum logic [1:0] {WAIT_KEY, WAIT_MSG, BUSY, RESULT} state_t;

  state_t                    state;
  logic                      cs_q;
  logic [8:0]                bit_cnt;
  logic [KEY_FRAME_BITS-1:0] in_sr;
  logic [BLK_BITS-1:0]       res_q;
  logic [BLK_BITS-1:0]       out_sr;
  logic                      start_pend;
  logic                      err_pend;

  logic eof;
  logic key_legal;
  logic blk_frame;

  assign eof       = cs && !cs_q;
  assign key_legal = (bit_cnt == KEY_LEN) &&
                     (in_sr[KEY_FRAME_BITS-1:KEY_FRAME_BITS-2] != 2'b11);
  assign blk_frame = (bit_cnt == BLK_LEN);

  // Read data must be on the wire in the very first cs-low cycle, so sdo is
  // gated combinationally by cs rather than registered.
  assign sdo = (state == RESULT) && !cs && out_sr[BLK_BITS-1];

  // Frame decisions are made on the end-of-frame edge; the resulting
  // core_start/frame_err pulses are staged one edge later via *_pend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_KEY;
      cs_q       <= 1'b1;
      bit_cnt    <= '0;
      in_sr      <= '0;
      res_q      <= '0;
      out_sr     <= '0;
      start_pend <= 1'b0;
      err_pend   <= 1'b0;
      core_start <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      key_valid  <= 1'b0;
      key_mode   <= '0;
      key        <= '0;
      block_out  <= '0;
    end else begin
      cs_q       <= cs;
      start_pend <= 1'b0;
      err_pend   <= 1'b0;
      core_start <= start_pend;
      frame_err  <= err_pend;
      busy       <= (state == BUSY);

      if (!cs) begin
        in_sr <= {in_sr[KEY_FRAME_BITS-2:0], sdi};
        if (cs_q) begin
          bit_cnt <= 9'd1;
        end else if (bit_cnt != 9'h1ff) begin
          bit_cnt <= bit_cnt + 9'd1;
        end
      end

      if (state == RESULT && !cs) begin
        out_sr <= {out_sr[BLK_BITS-2:0], 1'b0};
      end

      case (state)
        WAIT_KEY: begin
          if (eof) begin
            if (key_legal) begin
              key_mode  <= in_sr[KEY_FRAME_BITS-1:KEY_FRAME_BITS-2];
              key       <= in_sr[KEY_FRAME_BITS-3:0];
              key_valid <= 1'b1;
              state     <= WAIT_MSG;
            end else begin
              err_pend <= 1'b1;
            end
          end
        end

        WAIT_MSG: begin
          if (eof) begin
            if (blk_frame) begin
              block_out  <= in_sr[BLK_BITS-1:0];
              start_pend <= 1'b1;
              state      <= BUSY;
            end else if (key_legal) begin
              key_mode  <= in_sr[KEY_FRAME_BITS-1:KEY_FRAME_BITS-2];
              key       <= in_sr[KEY_FRAME_BITS-3:0];
              key_valid <= 1'b1;
            end else begin
              err_pend <= 1'b1;
            end
          end
        end

        BUSY: begin
          if (eof) begin
            err_pend <= 1'b1;
          end
          if (core_done) begin
            res_q  <= core_result;
            out_sr <= core_result;
            state  <= RESULT;
          end
        end

        RESULT: begin
          if (eof) begin
            if (blk_frame) begin
              state <= WAIT_MSG;
            end else if (key_legal) begin
              key_mode  <= in_sr[KEY_FRAME_BITS-1:KEY_FRAME_BITS-2];
              key       <= in_sr[KEY_FRAME_BITS-3:0];
              key_valid <= 1'b1;
              res_q     <= '0;
              out_sr    <= '0;
              state     <= WAIT_MSG;
            end else begin
              // Short/long read: rewind so the master can simply retry.
              err_pend <= 1'b1;
              out_sr   <= res_q;
            end
          end
        end

        default: state <= WAIT_KEY;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_frame_if.sv
// Directed bench for aes_spi_frame_if: key/data/read frames with a stub core
// driven from the stimulus sequence, checked by immediate assertions.
module tb_aes_spi_frame_if;

  localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY192 = 256'h0000000000000000000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs;
  logic         sdi;
  logic         sdo;
  logic [1:0]   key_mode;
  logic [255:0] key;
  logic         key_valid;
  logic [127:0] block_out;
  logic         core_start;
  logic         core_done;
  logic [127:0] core_result;
  logic         busy;
  logic         frame_err;

  int errors = 0;
  int checks = 0;

  logic [257:0] cap;
  logic [2:0]   err_seq;
  logic [2:0]   start_seq;

  aes_spi_frame_if #(.KEY_FRAME_BITS(258), .BLK_BITS(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .sdi         (sdi),
    .sdo         (sdo),
    .key_mode    (key_mode),
    .key         (key),
    .key_valid   (key_valid),
    .block_out   (block_out),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [257:0] observed,
                              input logic [257:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Shifts bits [nbits-1:0] of data MSB first, capturing sdo in each cs-low cycle.
  task automatic apply_stimulus(input logic [257:0] data, input int nbits,
                                output logic [257:0] sdo_cap);
    sdo_cap = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      cs  = 1'b0;
      sdi = data[i];
      #1;
      sdo_cap[i] = sdo;
    end
  endtask

  // Ends the frame and records frame_err/core_start after the next three edges.
  task automatic close_frame(input logic done_pulse, output logic [2:0] err_s,
                             output logic [2:0] start_s);
    @(negedge clk);
    cs  = 1'b1;
    sdi = 1'b0;
    if (done_pulse) begin
      core_done   = 1'b1;
      core_result = RES;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      err_s[k]   = frame_err;
      start_s[k] = core_start;
      core_done  = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    cs          = 1'b1;
    sdi         = 1'b0;
    core_done   = 1'b0;
    core_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("reset_sdo",       258'(sdo),        258'(0));
    check_output("reset_key_valid", 258'(key_valid),  258'(0));
    check_output("reset_key_mode",  258'(key_mode),   258'(0));
    check_output("reset_key",       258'(key),        258'(0));
    check_output("reset_block_out", 258'(block_out),  258'(0));
    check_output("reset_pulses",    258'({core_start, busy, frame_err}), 258'(0));

    // Illegal key mode 11 while waiting for a key
    apply_stimulus({2'b11, KEY128}, 258, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("mode11_err_seq",   258'(err_seq),   258'(3'b010));
    check_output("mode11_key_valid", 258'(key_valid), 258'(0));

    // AES-128 key
    apply_stimulus({2'b00, KEY128}, 258, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("key128_err_seq",   258'(err_seq),   258'(3'b000));
    check_output("key128_key_valid", 258'(key_valid), 258'(1));
    check_output("key128_key_mode",  258'(key_mode),  258'(2'b00));
    check_output("key128_key",       258'(key),       258'(KEY128));

    // 127-bit data frame is rejected and must not launch the core
    apply_stimulus(258'(PT), 127, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("short_err_seq",   258'(err_seq),   258'(3'b010));
    check_output("short_start_seq", 258'(start_seq), 258'(3'b000));

    // Correct plaintext frame launches the core
    apply_stimulus(258'(PT), 128, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("pt_start_seq", 258'(start_seq), 258'(3'b010));
    check_output("pt_err_seq",   258'(err_seq),   258'(3'b000));
    check_output("pt_block_out", 258'(block_out), 258'(PT));
    check_output("pt_busy",      258'(busy),      258'(1));

    // Read attempt while busy; stub core finishes on that frame's end edge
    apply_stimulus(258'(38'h2a_5555_aaaa), 38, cap);
    check_output("busy_mid_frame", 258'(busy), 258'(1));
    check_output("busy_sdo_zero",  cap,        258'(0));
    close_frame(1'b1, err_seq, start_seq);
    check_output("busy_err_seq",   258'(err_seq), 258'(3'b010));
    check_output("busy_fell",      258'(busy),    258'(0));

    // Short read is rejected, then a full read returns the result
    apply_stimulus('0, 100, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("read100_bits",    cap,            258'(RES >> 28));
    check_output("read100_err_seq", 258'(err_seq),  258'(3'b010));
    apply_stimulus('0, 128, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("read128_bits",    cap,            258'(RES));
    check_output("read128_err_seq", 258'(err_seq),  258'(3'b000));

    // Back in WAIT_MSG: re-key with AES-192
    apply_stimulus({2'b01, KEY192}, 258, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("key192_err_seq",  258'(err_seq),  258'(3'b000));
    check_output("key192_key_mode", 258'(key_mode), 258'(2'b01));
    check_output("key192_key",      258'(key),      258'(KEY192));

    // Mode 11 in WAIT_MSG leaves the key untouched
    apply_stimulus({2'b11, KEY256}, 258, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("msg_mode11_err_seq",  258'(err_seq),  258'(3'b010));
    check_output("msg_mode11_key",      258'(key),      258'(KEY192));
    check_output("msg_mode11_key_mode", 258'(key_mode), 258'(2'b01));

    // One-cycle reset in the middle of a key frame
    apply_stimulus(258'({2'b10, KEY256} >> 158), 100, cap);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cs    = 1'b1;
    #1;
    check_output("midrst_key_valid", 258'(key_valid), 258'(0));
    check_output("midrst_key",       258'(key),       258'(0));
    check_output("midrst_block_out", 258'(block_out), 258'(0));
    check_output("midrst_pulses",    258'({sdo, core_start, busy, frame_err, key_mode}), 258'(0));

    // Stray core_done outside BUSY is ignored
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    check_output("stray_done_busy", 258'(busy), 258'(0));

    apply_stimulus({2'b10, KEY256}, 258, cap);
    close_frame(1'b0, err_seq, start_seq);
    check_output("key256_err_seq",   258'(err_seq),   258'(3'b000));
    check_output("key256_key_valid", 258'(key_valid), 258'(1));
    check_output("key256_key_mode",  258'(key_mode),  258'(2'b10));
    check_output("key256_key",       258'(key),       258'(KEY256));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
